// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative EX-stage MULT/MULTU/DIV/DIVU unit with HI/LO results
//            and MFHI/MFLO stall. Optional macro: MULDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OPW        = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_regA,
    input  logic [DATA_WIDTH-1:0] i_regB,
    input  logic                  i_start,
    input  logic [OPW-1:0]        i_op,
    input  logic                  i_mf_req,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_stall
);

    localparam int              CW        = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [CW-1:0]             cnt;
    logic                      is_div;
    logic                      div_zero;
    logic                      neg_res;
    logic                      neg_rem;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic [2*DATA_WIDTH-1:0]   mcand;
    logic [DATA_WIDTH-1:0]     mplr;

    logic                      a_neg;
    logic                      b_neg;
    logic [DATA_WIDTH-1:0]     a_abs;
    logic [DATA_WIDTH-1:0]     b_abs;
    logic                      b_zero;
    logic                      calc_last;
    logic [2*DATA_WIDTH-1:0]   mul_next;
    logic [DATA_WIDTH:0]       div_tmp;
    logic [DATA_WIDTH:0]       div_diff;
    logic                      div_ge;
    logic [DATA_WIDTH-1:0]     div_rem;
    logic [2*DATA_WIDTH-1:0]   div_next;
    logic [2*DATA_WIDTH-1:0]   mul_res;
    logic [DATA_WIDTH-1:0]     quo;
    logic [DATA_WIDTH-1:0]     rem;
    logic [DATA_WIDTH-1:0]     quo_res;
    logic [DATA_WIDTH-1:0]     rem_res;

    assign a_neg  = ~i_op[0] & i_regA[DATA_WIDTH-1];
    assign b_neg  = ~i_op[0] & i_regB[DATA_WIDTH-1];
    assign a_abs  = a_neg ? (-i_regA) : i_regA;
    assign b_abs  = b_neg ? (-i_regB) : i_regB;
    assign b_zero = (i_regB == '0);

`ifdef MULDIV_EARLY_OUT_EN
    // Multiply may stop once no unconsumed multiplier bits remain set.
    assign calc_last = (cnt == LAST_ITER) |
                       (~is_div & (mplr[DATA_WIDTH-1:1] == '0));
`else
    assign calc_last = (cnt == LAST_ITER);
`endif

    assign mul_next = prod + (mplr[0] ? mcand : '0);

    // Restoring divide: prod holds {partial remainder, dividend/quotient}.
    assign div_tmp  = prod[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign div_diff = div_tmp - {1'b0, mplr};
    assign div_ge   = ~div_diff[DATA_WIDTH];
    assign div_rem  = div_ge ? div_diff[DATA_WIDTH-1:0] : div_tmp[DATA_WIDTH-1:0];
    assign div_next = {div_rem, prod[DATA_WIDTH-2:0], div_ge};

    assign mul_res  = neg_res ? (-prod) : prod;
    assign quo      = prod[DATA_WIDTH-1:0];
    assign rem      = prod[2*DATA_WIDTH-1:DATA_WIDTH];
    assign quo_res  = neg_res ? (-quo) : quo;
    assign rem_res  = neg_rem ? (-rem) : rem;

    assign o_stall  = i_mf_req & o_busy;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_start) next_state = CALC;
            CALC: begin
                if (div_zero) begin
                    next_state = DONE;
                end else if (calc_last) begin
                    next_state = SIGN;
                end
            end
            SIGN: next_state = DONE;
            DONE: next_state = i_start ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            prod     <= '0;
            mcand    <= '0;
            mplr     <= '0;
            o_hi     <= '0;
            o_lo     <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        cnt      <= '0;
                        is_div   <= i_op[1];
                        div_zero <= i_op[1] & b_zero;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        mcand    <= {{DATA_WIDTH{1'b0}}, a_abs};
                        mplr     <= b_abs;
                        // Divide-by-zero keeps the raw dividend for HI.
                        prod     <= i_op[1] ? {{DATA_WIDTH{1'b0}}, (b_zero ? i_regA : a_abs)}
                                            : '0;
                        o_busy   <= 1'b1;
                    end
                end
                CALC: begin
                    if (div_zero) begin
                        o_hi   <= prod[DATA_WIDTH-1:0];
                        o_lo   <= '1;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (is_div) begin
                            prod <= div_next;
                        end else begin
                            prod  <= mul_next;
                            mcand <= mcand << 1;
                            mplr  <= mplr >> 1;
                        end
                    end
                end
                SIGN: begin
                    if (is_div) begin
                        o_hi <= rem_res;
                        o_lo <= quo_res;
                    end else begin
                        o_hi <= mul_res[2*DATA_WIDTH-1:DATA_WIDTH];
                        o_lo <= mul_res[DATA_WIDTH-1:0];
                    end
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// Scoreboard bench for ex_muldiv_unit: expectations queued at start, checked on o_done.
module tb_ex_muldiv_unit;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_regA  = '0;
    logic [31:0] i_regB  = '0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op    = '0;
    logic        i_mf_req = 1'b0;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;
    logic        o_stall;

    ex_muldiv_unit #(.DATA_WIDTH(32), .OPW(2)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_regA  (i_regA),
        .i_regB  (i_regB),
        .i_start (i_start),
        .i_op    (i_op),
        .i_mf_req(i_mf_req),
        .o_hi    (o_hi),
        .o_lo    (o_lo),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_stall (o_stall)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin r = sa * sb; u = r; end
            2'd1: u = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) u = {a, 32'hFFFF_FFFF};
                else begin
                    r = sa % sb;
                    u[63:32] = r[31:0];
                    r = sa / sb;
                    u[31:0] = r[31:0];
                end
            end
            default: begin
                if (b == 0) u = {a, 32'hFFFF_FFFF};
                else u = {a % b, a / b};
            end
        endcase
        return u;
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int hb;
        if (op[1] && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            m = (op == 2'd0 && b[31]) ? -b : b;
            hb = 0;
            for (int k = 0; k < 32; k++) if (m[k]) hb = k;
            return hb + 2;
        end
`endif
        return 33;
    endfunction

    always @(negedge i_clock) begin
        if (!i_reset && o_done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("hi", {32'b0, o_hi}, {32'b0, e.hi});
                check("lo", {32'b0, o_lo}, {32'b0, e.lo});
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_at_done", {63'b0, o_busy}, 64'd0);
            end
        end
    end

    // Called at a negedge; leaves start asserted for exactly one edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        exp_t e;
        logic [63:0] r;
        r     = model(op, a, b);
        lat   = latency(op, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.cyc = cyc + 1 + lat;
        sbq.push_back(e);
        i_op = op; i_regA = a; i_regB = b; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge i_clock);
            n++;
        end
        check("timeout", 64'(sbq.size()), 64'd0);
        @(negedge i_clock);
    endtask

    initial begin
        int lat;
        int n;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        check("rst_hi",   {32'b0, o_hi}, 64'd0);
        check("rst_lo",   {32'b0, o_lo}, 64'd0);
        check("rst_busy", {63'b0, o_busy}, 64'd0);
        check("rst_done", {63'b0, o_done}, 64'd0);
        @(negedge i_clock);

        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, lat);
        for (int k = 0; k < lat; k++) begin
            check("busy_during", {63'b0, o_busy}, 64'd1);
            @(negedge i_clock);
        end
        wait_empty();

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, lat);  wait_empty();
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat);  wait_empty();
        run_op(2'd3, 32'd100, 32'd0, lat);        wait_empty();
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, lat);  wait_empty();
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat); wait_empty();

        // Start while busy is ignored; stall follows busy.
        run_op(2'd3, 32'd1000, 32'd7, lat);
        repeat (3) @(negedge i_clock);
        i_op = 2'd1; i_regA = 32'd3; i_regB = 32'd3; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        i_mf_req = 1'b1;
        #1 check("stall_busy", {63'b0, o_stall}, 64'd1);
        @(negedge i_clock);
        i_mf_req = 1'b0;
        #1 check("stall_off", {63'b0, o_stall}, 64'd0);
        wait_empty();
        i_mf_req = 1'b1;
        #1 check("stall_idle", {63'b0, o_stall}, 64'd0);
        @(negedge i_clock);
        i_mf_req = 1'b0;

        // Reset mid-operation.
        i_op = 2'd1; i_regA = 32'h1234_5678; i_regB = 32'h9ABC_DEF0; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        repeat (9) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        check("mrst_busy", {63'b0, o_busy}, 64'd0);
        check("mrst_hi",   {32'b0, o_hi}, 64'd0);
        check("mrst_lo",   {32'b0, o_lo}, 64'd0);
        check("mrst_done", {63'b0, o_done}, 64'd0);
        i_reset = 1'b0;
        @(negedge i_clock);
        run_op(2'd1, 32'd5, 32'd6, lat);  wait_empty();

        // Back-to-back start during the done cycle.
        run_op(2'd1, 32'd11, 32'd13, lat);
        n = 0;
        while (!o_done && n < 100) begin
            @(negedge i_clock);
            n++;
        end
        check("b2b_first_done", {63'b0, o_done}, 64'd1);
        run_op(2'd2, 32'd9, 32'd3, lat);
        wait_empty();

        run_op(2'd1, 32'd5, 32'd3, lat);  wait_empty();
        run_op(2'd0, 32'd0, 32'd0, lat);  wait_empty();

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            run_op(op, a, b, lat);
            wait_empty();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
